// File: rtl/divider_fixed_point_16_bit_if.sv
// Operand/result handshake bundle for the Q3.12 fixed-point divider.
interface divider_fixed_point_16_bit_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q_result;
    logic         overflow;
    logic         div_by_zero;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q_result, overflow, div_by_zero
    );

    // Divider side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q_result, overflow, div_by_zero
    );
endinterface

// File: rtl/divider_fixed_point_16_bit.sv
// Iterative signed fixed-point divider, q = a / b in Q(N-Q-1).Q, one quotient bit per clock.
// Restoring core works on magnitudes; sign is reapplied and the result saturated on DONE entry.
module divider_fixed_point_16_bit #(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    divider_fixed_point_16_bit_if.slave  bus
);
    localparam int unsigned W  = N + Q;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [W-1:0] POS_LIMIT = W'((2 ** (N - 1)) - 1);
    localparam logic [W-1:0] NEG_LIMIT = W'(2 ** (N - 1));
    localparam logic [N-1:0] Q_MAX     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_MIN     = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [N-1:0]    bmag_q, bmag_d;
    logic [W-1:0]    num_q, num_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    q_q, q_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            accept_c;
    logic            handoff_c;
    logic            b_zero_c;
    logic [N-1:0]    a_mag_c;
    logic [N-1:0]    b_mag_c;
    logic [N:0]      rem_sh_c;
    logic            ge_c;
    logic [W-1:0]    mag_c;

    assign accept_c  = bus.in_valid & in_ready_q;
    assign handoff_c = out_valid_q & bus.out_ready;
    assign b_zero_c  = (bus.b == '0);
    assign a_mag_c   = bus.a[N-1] ? N'(-bus.a) : bus.a;
    assign b_mag_c   = bus.b[N-1] ? N'(-bus.b) : bus.b;

    // One restoring step: numerator MSB shifts into the remainder, quotient bit into num LSB
    assign rem_sh_c  = {rem_q, num_q[W-1]};
    assign ge_c      = (rem_sh_c >= {1'b0, bmag_q});
    assign mag_c     = {num_q[W-2:0], ge_c};

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            bmag_q      <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            bmag_q      <= bmag_d;
            num_q       <= num_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = b_zero_c ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  if (handoff_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        sign_d      = sign_q;
        bmag_d      = bmag_q;
        num_d       = num_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    sign_d     = bus.a[N-1] ^ bus.b[N-1];
                    bmag_d     = b_mag_c;
                    num_d      = {a_mag_c, {Q{1'b0}}};
                    rem_d      = '0;
                    cnt_d      = CW'(W);
                    in_ready_d = 1'b0;
                    if (b_zero_c) begin
                        dbz_d = 1'b1;
                        ovf_d = 1'b0;
                        q_d   = bus.a[N-1] ? Q_MIN : Q_MAX;
                    end
                end
            end
            S_CALC: begin
                rem_d = ge_c ? N'(rem_sh_c - {1'b0, bmag_q}) : rem_sh_c[N-1:0];
                num_d = mag_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_valid_d = 1'b1;
                    dbz_d       = 1'b0;
                    if (sign_q && (mag_c != '0)) begin
                        ovf_d = (mag_c > NEG_LIMIT);
                        q_d   = (mag_c > NEG_LIMIT) ? Q_MIN : -mag_c[N-1:0];
                    end else begin
                        ovf_d = (mag_c > POS_LIMIT);
                        q_d   = (mag_c > POS_LIMIT) ? Q_MAX : mag_c[N-1:0];
                    end
                end
            end
            S_DONE: begin
                // Divide-by-zero enters DONE directly; its result is presented one edge later
                if (!out_valid_q) out_valid_d = 1'b1;
                if (handoff_c) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.q_result    = q_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_fixed_point_16_bit.sv
module tb_divider_fixed_point_16_bit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    divider_fixed_point_16_bit_if #(.N(16)) dif ();

    divider_fixed_point_16_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: exact rational quotient truncated toward zero, then saturated.
    // Returns {div_by_zero, overflow, q}.
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv);
        longint sa, sb, qq;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (bv == 16'h0000)
            return {1'b1, 1'b0, (av[15] ? 16'h8000 : 16'h7FFF)};
        qq = (sa * 4096) / sb;
        if (qq > 32767)  return {1'b0, 1'b1, 16'h7FFF};
        if (qq < -32768) return {1'b0, 1'b1, 16'h8000};
        return {1'b0, 1'b0, 16'(qq)};
    endfunction

    // Full transaction: accept, measure latency, check result, hold, hand off
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input int hold);
        logic [17:0] exp;
        int          lat;
        int          waited;
        logic [15:0] q_seen;
        exp = model(av, bv);
        waited = 0;
        while (!dif.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        dif.in_valid = 1'b1;
        dif.a        = av;
        dif.b        = bv;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        dif.a        = 16'($urandom);
        dif.b        = 16'($urandom);
        lat = 0;
        while (!dif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), (bv == 16'h0000) ? 32'd1 : 32'd28);
        check("q_result", 32'(dif.q_result), 32'(exp[15:0]));
        check("overflow", 32'(dif.overflow), 32'(exp[16]));
        check("div_by_zero", 32'(dif.div_by_zero), 32'(exp[17]));
        q_seen = dif.q_result;
        for (int i = 0; i < hold; i++) begin
            dif.in_valid = 1'b1;
            dif.a        = 16'($urandom);
            dif.b        = 16'($urandom);
            @(posedge clk); #1;
            check("hold_q", 32'(dif.q_result), 32'(q_seen));
            check("hold_valid", 32'(dif.out_valid), 32'd1);
            check("hold_in_ready", 32'(dif.in_ready), 32'd0);
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        check("handoff_valid", 32'(dif.out_valid), 32'd0);
        check("handoff_in_ready", 32'(dif.in_ready), 32'd1);
        check("idle_flags", {30'd0, dif.overflow, dif.div_by_zero}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb;
        int          sel;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.a         = 16'h0000;
        dif.b         = 16'h0000;
        dif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(dif.in_ready), 32'd1);
        check("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_q", 32'(dif.q_result), 32'd0);
        check("rst_flags", {30'd0, dif.overflow, dif.div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_op(16'h1800, 16'h2000, 0);
        do_op(16'hE800, 16'h2000, 0);
        do_op(16'hF000, 16'h3000, 1);
        do_op(16'h7FFF, 16'h0800, 0);
        do_op(16'h8000, 16'h1000, 0);
        do_op(16'hC000, 16'h0000, 0);
        do_op(16'h0000, 16'h0000, 0);
        do_op(16'h0000, 16'h9000, 0);
        do_op(16'h8000, 16'hF000, 0);
        do_op(16'h1800, 16'h2000, 5);

        // Reset in the middle of CALC discards the operation
        dif.in_valid = 1'b1;
        dif.a        = 16'h1800;
        dif.b        = 16'h2000;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
        check("midrst_in_ready", 32'(dif.in_ready), 32'd1);
        check("midrst_q", 32'(dif.q_result), 32'd0);
        do_op(16'h1800, 16'h2000, 0);

        // Randomized operands, biased toward zero and small divisors
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra  = 16'($urandom);
            if (sel == 0)
                rb = 16'h0000;
            else if (sel <= 3) begin
                rb = 16'($urandom_range(1, 255));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                rb = 16'($urandom);
            end
            do_op(ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
